// File: rtl/funsel_reg_file.sv
// funsel_reg_file: bank of DEPTH general-purpose registers sharing one
// function-select code (clear / load / decrement / increment), applied to
// every register whose enable bit is set. Two combinational read ports feed
// the datapath; a registered per-register flag reports counter wrap.
//
// Optional feature macro: FUNSEL_SATURATE_EN
//   defined   -> increment of all-ones and decrement of zero clamp instead of
//                wrapping; the flag still reports the clamp.
//   undefined -> modular wrap-around.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset (registers and flags to 0)
//   fun_sel    00 clear, 01 load, 10 decrement, 11 increment
//   reg_en     per-register enable mask (multi-hot allowed, 0 = no-op)
//   data_in    load value
//   rd_a_sel   read port A index (index >= DEPTH reads 0)
//   rd_b_sel   read port B index (index >= DEPTH reads 0)
//   rd_a/rd_b  current contents of the selected registers (no bypass)
//   wrap       registered OR of wrap_mask
//   wrap_mask  registered per-register wrap/clamp indication of last edge
module funsel_reg_file #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       fun_sel,
    input  logic [DEPTH-1:0] reg_en,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0] rd_a_sel,
    input  logic [SEL_W-1:0] rd_b_sel,
    output logic [WIDTH-1:0] rd_a,
    output logic [WIDTH-1:0] rd_b,
    output logic             wrap,
    output logic [DEPTH-1:0] wrap_mask
);

    typedef enum logic [1:0] {
        FS_CLEAR = 2'b00,
        FS_LOAD  = 2'b01,
        FS_DEC   = 2'b10,
        FS_INC   = 2'b11
    } fun_e;

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ZERO     = '0;

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0] wrap_mask_q;
    logic [DEPTH-1:0] wrap_mask_d;
    logic             wrap_q;
    fun_e             fun;

    assign fun = fun_e'(fun_sel);

    // Next value and boundary flag for every register, each on its own value.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            regs_d[i]      = regs_q[i];
            wrap_mask_d[i] = 1'b0;
            if (reg_en[i]) begin
                case (fun)
                    FS_CLEAR: regs_d[i] = ZERO;
                    FS_LOAD:  regs_d[i] = data_in;
                    FS_DEC: begin
                        wrap_mask_d[i] = (regs_q[i] == ZERO);
`ifdef FUNSEL_SATURATE_EN
                        if (regs_q[i] != ZERO) regs_d[i] = regs_q[i] - WIDTH'(1);
`else
                        regs_d[i] = regs_q[i] - WIDTH'(1);
`endif
                    end
                    FS_INC: begin
                        wrap_mask_d[i] = (regs_q[i] == ALL_ONES);
`ifdef FUNSEL_SATURATE_EN
                        if (regs_q[i] != ALL_ONES) regs_d[i] = regs_q[i] + WIDTH'(1);
`else
                        regs_d[i] = regs_q[i] + WIDTH'(1);
`endif
                    end
                    default: regs_d[i] = regs_q[i];
                endcase
            end
        end
    end

    // Register array and flags; reset overrides any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= ZERO;
            end
            wrap_mask_q <= '0;
            wrap_q      <= 1'b0;
        end else begin
            regs_q      <= regs_d;
            wrap_mask_q <= wrap_mask_d;
            wrap_q      <= |wrap_mask_d;
        end
    end

    // Read muxes: a compare loop rather than direct indexing so that
    // out-of-range selects (non power-of-two DEPTH) return zero.
    always_comb begin
        rd_a = ZERO;
        rd_b = ZERO;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (rd_a_sel == SEL_W'(i)) rd_a = regs_q[i];
            if (rd_b_sel == SEL_W'(i)) rd_b = regs_q[i];
        end
    end

    assign wrap      = wrap_q;
    assign wrap_mask = wrap_mask_q;

endmodule

// File: doc/funsel_reg_file.md
Name: funsel_reg_file

Overview:
- Parametrised bank of DEPTH general-purpose registers, each WIDTH bits wide.
- Registers share one 2-bit function-select operation code: clear, load, decrement, increment.
- A one-hot-or-multi-hot enable mask selects which registers the operation touches.
- Two independent read ports feed the datapath (ALU operand A/B), and a registered wrap flag reports counter overflow/underflow. This block is the general register file of the datapath, replacing fixed-width single registers.

Parameters:
- WIDTH, 8, bit width of each register and of data_in/read ports (>= 2)
- DEPTH, 4, number of registers (2..16)
- SEL_W, $clog2(DEPTH), read-select width (derived, not overridden)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- fun_sel  input  2  operation: 00 clear, 01 load, 10 decrement, 11 increment
- reg_en  input  DEPTH  per-register enable mask; bit i set = register i executes fun_sel this cycle
- data_in  input  WIDTH  load value
- rd_a_sel  input  SEL_W  read port A register index
- rd_b_sel  input  SEL_W  read port B register index
- rd_a  output  WIDTH  contents of register rd_a_sel
- rd_b  output  WIDTH  contents of register rd_b_sel
- wrap  output  1  registered: any enabled register wrapped (or clamped) on the last edge
- wrap_mask  output  DEPTH  registered: per-register wrap indication for the last edge

Behaviour:
- Reset:
  - When rst=1 at a rising edge, all registers become 0, and wrap and wrap_mask become 0.
  - rst overrides reg_en/fun_sel, including mid-operation; the first post-reset edge with rst=0 operates normally.
- Per edge, for each register i:
  - If reg_en[i]=0, the register holds.
  - If reg_en[i]=1, the register takes: 00 -> 0; 01 -> data_in; 10 -> reg-1 mod 2^WIDTH; 11 -> reg+1 mod 2^WIDTH.
- Multi-hot reg_en:
  - All selected registers perform the same operation in the same cycle, each on its own current value.
  - reg_en=0 is a legal no-op.
- Latency: one cycle from operation to new register value.
- Read ports:
  - Reads are combinational from current register state, with no write-through bypass.
  - rd_a/rd_b show the pre-edge value during the operation cycle and the updated value after the edge.
  - An index >= DEPTH returns 0.
  - A and B may select the same register.
- wrap_mask[i]:
  - Set to 1 on an edge where reg_en[i]=1 and either fun_sel=11 with reg = all-ones, or fun_sel=10 with reg = 0. Otherwise it is set to 0.
  - Recomputed every edge; not sticky.
  - wrap = OR of wrap_mask.
- Clear and load never assert wrap.
- No internal state machine beyond the register array and the flag registers. All outputs are deterministic after the first reset.

Optional Feature:
- Macro: FUNSEL_SATURATE_EN.
- Defined:
  - Increment of all-ones holds at all-ones, and decrement of 0 holds at 0.
  - wrap_mask/wrap flag the clamp under the same conditions as a wrap.
- Undefined: modular wrap-around as specified above.
- Clear, load and the read paths are unaffected either way.

Test Plan (WIDTH=8, DEPTH=4):
- Reset: rst=1 for one edge after arbitrary loads -> all rd values 0x00, wrap=0; rst asserted with fun_sel=01, reg_en=4'b1111, data_in=0xAA -> registers stay 0x00.
- Load/read: load 0x11,0x22,0x33,0x44 into R0..R3 one at a time; rd_a_sel=2, rd_b_sel=3 -> rd_a=0x33, rd_b=0x44. During the load cycle, rd shows the old value; the new value appears after the edge.
- Multi-hot increment: R0=0x10, R2=0xFE; fun_sel=11, reg_en=4'b0101 for 2 edges -> after edge 1, R0=0x11 and R2=0xFF with wrap=0; after edge 2, R0=0x12 and R2=0x00 with wrap_mask=4'b0100, wrap=1; next idle edge -> wrap=0.
- Decrement underflow: R1=0x00, fun_sel=10, reg_en=4'b0010 -> R1=0xFF and wrap_mask=4'b0010 (with FUNSEL_SATURATE_EN: R1=0x00, wrap_mask=4'b0010).
- Hold/clear: reg_en=0 with fun_sel=00 -> no change; then reg_en=4'b1000, fun_sel=00 -> R3=0x00, others unchanged, wrap=0.
- Out-of-range/shared select: configure DEPTH=3; rd_a_sel=3 -> rd_a=0x00; rd_a_sel=rd_b_sel=1 -> both equal R1.
